// File: rtl/aes_req_arbiter.sv
// -----------------------------------------------------------------------------
// aes_req_arbiter
//   Shares a single, unmodified AES core among N_REQ requesters. Jobs are
//   granted round-robin with one job outstanding at a time. The arbiter pulses
//   the core start, waits for a genuine ready (a level that was already high at
//   launch is ignored), and returns the result to the granted requester. A job
//   whose core never answers is abandoned after TIMEOUT_CYCLES with an error.
//   The latency of the last completed job is kept for observation.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid_i       per-requester job request
//   req_ready_o       one-hot acceptance of a job (combinational, IDLE only)
//   req_enc_dec_i     per-requester mode, 1 = encrypt
//   req_data_i        per-requester 128-bit block, requester i at [128*i+:128]
//   req_key_i         per-requester 128-bit key,   requester i at [128*i+:128]
//   rsp_valid_o       one-hot result valid, held until the matching rsp_ready_i
//   rsp_ready_i       per-requester result acceptance
//   rsp_data_o        result block (zero on timeout)
//   rsp_err_o         1 = job timed out
//   core_start_o      one-cycle start pulse to the AES core
//   core_enc_dec_o    mode to the core
//   core_data_in_o    block to the core
//   core_key_in_o     key to the core
//   core_data_out_i   core result
//   core_ready_i      core done indicator (pulse or level)
//   busy_o            1 while a job is in flight
//   last_cycles_o     cycles from start to ready of the last completed job
// -----------------------------------------------------------------------------
module aes_req_arbiter #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ-1:0]       req_enc_dec_i,
  input  logic [128*N_REQ-1:0]   req_data_i,
  input  logic [128*N_REQ-1:0]   req_key_i,
  output logic [N_REQ-1:0]       rsp_valid_o,
  input  logic [N_REQ-1:0]       rsp_ready_i,
  output logic [127:0]           rsp_data_o,
  output logic                   rsp_err_o,
  output logic                   core_start_o,
  output logic                   core_enc_dec_o,
  output logic [127:0]           core_data_in_o,
  output logic [127:0]           core_key_in_o,
  input  logic [127:0]           core_data_out_i,
  input  logic                   core_ready_i,
  output logic                   busy_o,
  output logic [CNT_W-1:0]       last_cycles_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W:0]     N_REQ_W  = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0]   RR_RST   = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_W = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic                hold_enc_q, hold_enc_d;
  logic [127:0]        hold_data_q, hold_data_d;
  logic [127:0]        hold_key_q, hold_key_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic [127:0]        rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]    last_cycles_q, last_cycles_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic                core_start_q, core_start_d;
  logic                busy_q, busy_d;

  logic                gnt_found_s;
  logic [IDX_W-1:0]    gnt_idx_s;
  logic [N_REQ-1:0]    gnt_oh_s;
  logic                sel_enc_s;
  logic [127:0]        sel_data_s;
  logic [127:0]        sel_key_s;
  logic [CNT_W-1:0]    cnt_plus1_s;
  logic                done_s;
  logic                tout_s;

  // Round-robin search: first requesting index after rr_ptr_q, wrapping.
  always_comb begin
    logic [IDX_W:0] cand;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= N_REQ_W) begin
        cand = cand - N_REQ_W;
      end else begin
        cand = cand;
      end
      if (!gnt_found_s && req_valid_i[cand[IDX_W-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand[IDX_W-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // AND-OR mux of the candidate's job fields.
  always_comb begin
    gnt_oh_s   = onehot(gnt_idx_s);
    sel_enc_s  = 1'b0;
    sel_data_s = '0;
    sel_key_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_enc_s  = sel_enc_s  | (gnt_oh_s[i] & req_enc_dec_i[i]);
      sel_data_s = sel_data_s | ({128{gnt_oh_s[i]}} & req_data_i[128*i +: 128]);
      sel_key_s  = sel_key_s  | ({128{gnt_oh_s[i]}} & req_key_i[128*i +: 128]);
    end
  end

  // Completion needs an armed ready; timeout only fires if completion does not.
  always_comb begin
    cnt_plus1_s = cnt_q + CNT_W'(1);
    done_s      = (state_q == ST_WAIT) && core_ready_i && armed_q;
    tout_s      = (state_q == ST_WAIT) && (cnt_plus1_s == TIMEOUT_W) && !done_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found_s) state_d = ST_LAUNCH;
        else             state_d = ST_IDLE;
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_s || tout_s) state_d = ST_RESP;
        else                  state_d = ST_WAIT;
      end
      ST_RESP: begin
        if (rsp_ready_i[grant_q]) state_d = ST_IDLE;
        else                      state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: next values of the registered strobes plus the combinational accept.
  always_comb begin
    core_start_d = (state_d == ST_LAUNCH);
    busy_d       = (state_d != ST_IDLE);
    if (state_d == ST_RESP) begin
      rsp_valid_d = onehot(grant_q);
    end else begin
      rsp_valid_d = '0;
    end
    if ((state_q == ST_IDLE) && gnt_found_s) begin
      req_ready_o = gnt_oh_s;
    end else begin
      req_ready_o = '0;
    end
  end

  // Datapath next-state: job capture, wait counter, result capture, rr update.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    hold_enc_d    = hold_enc_q;
    hold_data_d   = hold_data_q;
    hold_key_d    = hold_key_q;
    cnt_d         = cnt_q;
    armed_d       = armed_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    last_cycles_d = last_cycles_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found_s) begin
          grant_d     = gnt_idx_s;
          hold_enc_d  = sel_enc_s;
          hold_data_d = sel_data_s;
          hold_key_d  = sel_key_s;
        end else begin
          grant_d     = grant_q;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        armed_d = 1'b0;
      end
      ST_WAIT: begin
        if (cnt_q < TIMEOUT_W) cnt_d = cnt_plus1_s;
        else                   cnt_d = cnt_q;
        // A ready already high at launch is stale until it has been seen low.
        armed_d = armed_q | ~core_ready_i;
        if (done_s) begin
          rsp_data_d    = core_data_out_i;
          rsp_err_d     = 1'b0;
          last_cycles_d = cnt_plus1_s;
        end else if (tout_s) begin
          rsp_data_d    = '0;
          rsp_err_d     = 1'b1;
          last_cycles_d = TIMEOUT_W;
        end else begin
          rsp_data_d    = rsp_data_q;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i[grant_q]) rr_ptr_d = grant_q;
        else                      rr_ptr_d = rr_ptr_q;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= RR_RST;
      grant_q       <= '0;
      hold_enc_q    <= 1'b0;
      hold_data_q   <= '0;
      hold_key_q    <= '0;
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      last_cycles_q <= '0;
      rsp_valid_q   <= '0;
      core_start_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      hold_enc_q    <= hold_enc_d;
      hold_data_q   <= hold_data_d;
      hold_key_q    <= hold_key_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      last_cycles_q <= last_cycles_d;
      rsp_valid_q   <= rsp_valid_d;
      core_start_q  <= core_start_d;
      busy_q        <= busy_d;
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_err_o      = rsp_err_q;
  assign core_start_o   = core_start_q;
  assign core_enc_dec_o = hold_enc_q;
  assign core_data_in_o = hold_data_q;
  assign core_key_in_o  = hold_key_q;
  assign busy_o         = busy_q;
  assign last_cycles_o  = last_cycles_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aes_req_arbiter
//   Directed bench for aes_req_arbiter with a behavioural AES core stand-in.
//   The stand-in returns the FIPS-197 C.1 vector pair for the FIPS key and
//   data^key (encrypt) / ~(data^key) (decrypt) otherwise, after core_lat cycles.
//   Expected responses are queued when jobs are issued; a monitor pops and
//   compares on each response handshake.
// -----------------------------------------------------------------------------
module tb_aes_req_arbiter;

  localparam int N = 2;
  localparam logic [127:0] K_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] JUNK   = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
  localparam logic [127:0] D0 = 128'h0123456789abcdef0011223344556677;
  localparam logic [127:0] D1 = 128'hfedcba98765432108899aabbccddeeff;
  localparam logic [127:0] K0 = 128'hffff0000ffff0000a5a5a5a55a5a5a5a;
  localparam logic [127:0] K1 = 128'h13579bdf2468ace00f0f0f0ff0f0f0f0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     req_enc_dec = '0;
  logic [128*N-1:0] req_data = '0;
  logic [128*N-1:0] req_key = '0;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready = '1;
  logic [127:0]     rsp_data;
  logic             rsp_err;
  logic             core_start;
  logic             core_enc_dec;
  logic [127:0]     core_data_in;
  logic [127:0]     core_key_in;
  logic [127:0]     core_data_out;
  logic             core_ready;
  logic             busy;
  logic [15:0]      last_cycles;

  aes_req_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(200), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_enc_dec_i(req_enc_dec),
    .req_data_i(req_data), .req_key_i(req_key),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err),
    .core_start_o(core_start), .core_enc_dec_o(core_enc_dec),
    .core_data_in_o(core_data_in), .core_key_in_o(core_key_in),
    .core_data_out_i(core_data_out), .core_ready_i(core_ready),
    .busy_o(busy), .last_cycles_o(last_cycles)
  );

  // ---------------- AES core stand-in ----------------
  int           core_lat = 5;
  logic         core_never = 1'b0;
  logic         stale = 1'b0;
  logic         m_busy;
  int           m_cnt;
  logic         m_ready;
  logic [127:0] m_out;
  logic [127:0] m_data;
  logic [127:0] m_key;
  logic         m_enc;

  function automatic logic [127:0] fake_aes(input logic enc, input logic [127:0] d,
                                            input logic [127:0] k);
    if (k == K_FIPS && d == P_FIPS && enc)  return C_FIPS;
    if (k == K_FIPS && d == C_FIPS && !enc) return P_FIPS;
    if (enc) return d ^ k;
    return ~(d ^ k);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_cnt <= 0; m_ready <= 1'b0; m_out <= '0;
      m_data <= '0; m_key <= '0; m_enc <= 1'b0;
    end else begin
      m_ready <= 1'b0;
      if (core_start) begin
        m_busy <= 1'b1; m_cnt <= 1;
        m_data <= core_data_in; m_key <= core_key_in; m_enc <= core_enc_dec;
      end else if (m_busy) begin
        if (m_cnt == core_lat - 1) begin
          m_busy <= 1'b0;
          if (!core_never) begin
            m_ready <= 1'b1;
            m_out   <= fake_aes(m_enc, m_data, m_key);
          end
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  assign core_ready    = m_ready | stale;
  assign core_data_out = stale ? JUNK : m_out;

  // ---------------- scoreboard ----------------
  typedef struct {
    int           idx;
    logic [127:0] data;
    logic         err;
    logic [15:0]  cyc;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [127:0] d, input logic e, input logic [15:0] c);
    exp_t x;
    x.idx = idx; x.data = d; x.err = e; x.cyc = c;
    exp_q.push_back(x);
  endtask

  task automatic monitor();
    exp_t e;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (core_start) start_cnt++;
      if (rst_n && ((rsp_valid & rsp_ready) != '0)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 128'(rsp_valid), 128'(0));
        end else begin
          e  = exp_q.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          chk("rsp_valid", 128'(rsp_valid), 128'(oh));
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", 128'(rsp_err), 128'(e.err));
          chk("last_cycles", 128'(last_cycles), 128'(e.cyc));
        end
      end
    end
  endtask

  // Present a job on requester idx, wait for its grant, then withdraw it.
  task automatic issue(input int idx, input logic enc, input logic [127:0] d,
                       input logic [127:0] k);
    int n = 0;
    req_enc_dec[idx] = enc;
    req_data[128*idx +: 128] = d;
    req_key[128*idx +: 128]  = k;
    req_valid[idx] = 1'b1;
    @(negedge clk);
    while (!req_ready[idx] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("grant", 128'(req_ready[idx]), 128'(1'b1));
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int   n = 0;
    logic ok;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (exp_q.size() == 0) && !busy;
    chk("job_done", 128'(ok), 128'(1'b1));
    @(posedge clk); #1;
  endtask

  initial begin
    int g;
    int n;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_core_start", 128'(core_start), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_last_cycles", 128'(last_cycles), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1) Single FIPS encrypt on requester 0
    start_cnt = 0;
    push(0, C_FIPS, 1'b0, 16'd5);
    issue(0, 1'b1, P_FIPS, K_FIPS);
    wait_done(200);
    chk("start_pulses", 128'(start_cnt), 128'(1));

    // 3) Latency 32, FIPS decrypt on requester 1
    core_lat = 32;
    push(1, P_FIPS, 1'b0, 16'd32);
    issue(1, 1'b0, C_FIPS, K_FIPS);
    wait_done(200);
    core_lat = 5;

    // 2) Contention: both held, expect 0,1,0,1
    push(0, D0 ^ K0, 1'b0, 16'd5);
    push(1, D1 ^ K1, 1'b0, 16'd5);
    push(0, D0 ^ K0, 1'b0, 16'd5);
    push(1, D1 ^ K1, 1'b0, 16'd5);
    req_enc_dec = 2'b11;
    req_data = {D1, D0};
    req_key  = {K1, K0};
    req_valid = 2'b11;
    g = 0; n = 0;
    while (g < 4 && n < 400) begin
      @(negedge clk);
      if (req_ready != '0) g++;
      n++;
    end
    @(posedge clk); #1;
    req_valid = '0;
    chk("contention_grants", 128'(g), 128'(4));
    wait_done(200);

    // 4) Timeout, then a normal job
    core_never = 1'b1;
    push(0, 128'd0, 1'b1, 16'd200);
    issue(0, 1'b1, D0, K0);
    wait_done(400);
    core_never = 1'b0;
    push(1, D1 ^ K1, 1'b0, 16'd5);
    issue(1, 1'b1, D1, K1);
    wait_done(200);

    // 5) Stale ready held over grant, launch and first wait cycle
    push(0, D0 ^ K1, 1'b0, 16'd5);
    req_enc_dec[0] = 1'b1;
    req_data[127:0] = D0;
    req_key[127:0]  = K1;
    stale = 1'b1;
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("stale_grant", 128'(req_ready), 128'(2'b01));
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stale = 1'b0;
    wait_done(200);

    // 6a) Backpressure on requester 1; requester 0's ready must be ignored
    rsp_ready = 2'b01;
    push(1, D1 ^ K0, 1'b0, 16'd5);
    issue(1, 1'b1, D1, K0);
    n = 0;
    @(negedge clk);
    while (rsp_valid == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_valid", 128'(rsp_valid), 128'(2'b10));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 128'(rsp_valid), 128'(2'b10));
      chk("bp_hold_data", rsp_data, D1 ^ K0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    wait_done(200);

    // 6b) Reset during WAIT: outputs clear at once, no response, fresh job after
    core_never = 1'b1;
    issue(0, 1'b1, D0, K0);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_core_start", 128'(core_start), 128'(0));
    chk("arst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("arst_rsp_data", rsp_data, 128'd0);
    chk("arst_rsp_err", 128'(rsp_err), 128'(0));
    chk("arst_last_cycles", 128'(last_cycles), 128'(0));
    chk("arst_core_data_in", core_data_in, 128'd0);
    chk("arst_core_key_in", core_key_in, 128'd0);
    core_never = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(0, D1 ^ K1, 1'b0, 16'd5);
    issue(0, 1'b1, D1, K1);
    wait_done(200);

    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
